// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and the loader/debug DMA.
// One transaction at a time; reads wait RD_LAT cycles and return registered data plus a one-cycle valid.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          dbg_state
);
  // Handshake: a request is held until its gnt; gnt marks the single cycle the access
  // reaches memory, so anything the requester changes after gnt is ignored.
  typedef enum logic {S_IDLE = 1'b0, S_RD_WAIT = 1'b1} state_e;
  localparam logic       WIN_CPU  = 1'b0;
  localparam logic       WIN_DMA  = 1'b1;
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

  state_e        state_q, state_d;
  logic          last_win_q, last_win_d;
  logic          owner_q, owner_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic          cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
  logic          cpu_win, dma_win, win_we;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      cpu_win = cpu_req && (!dma_req || last_win_q == WIN_DMA);
      dma_win = dma_req && (!cpu_req || last_win_q == WIN_CPU);
    end
  end

  assign win_we = (cpu_win & cpu_we) | (dma_win & dma_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_win_q   <= WIN_DMA;
      owner_q      <= WIN_CPU;
      lat_cnt_q    <= 4'd0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_win_q   <= last_win_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_win_d   = last_win_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (cpu_win || dma_win) begin
        last_win_d = dma_win;
        // Writes finish in the grant cycle; only reads park the port.
        if (!win_we) begin
          owner_d   = dma_win;
          lat_cnt_d = LAT_INIT;
          state_d   = S_RD_WAIT;
        end
      end
    end else begin
      lat_cnt_d = lat_cnt_q - 4'd1;
      if (lat_cnt_q == 4'd1) begin
        state_d = S_IDLE;
        if (owner_q == WIN_DMA) begin
          dma_rdata_d  = mem_rdata;
          dma_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cpu_gnt   = cpu_win;
    dma_gnt   = dma_win;
    mem_en    = cpu_win | dma_win;
    mem_we    = win_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
    cpu_stall = !reset && ((cpu_req && !cpu_win) ||
                           (state_q == S_RD_WAIT && owner_q == WIN_CPU));
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dbg_state  = (state_q == S_RD_WAIT);

endmodule
